// File: rtl/video_gen_pkg.sv
// ============================================================================
// Module  : video_gen_pkg
// Brief   : Shared types and constants for the synthetic video stream source.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package video_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_V_LEAD  = 2'd1,
        S_ACTIVE  = 2'd2,
        S_V_BLANK = 2'd3
    } vstate_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci LFSR, taps 7/5/4/3
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_pattern_unit.sv
// ============================================================================
// Module  : video_pattern_unit
// Brief   : Maps pixel coordinates and latched pattern to a gray value.
//           VIDEO_GEN_NOISE_EN turns pattern 3 into an LFSR noise source.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module video_pattern_unit
    import video_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pattern,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] const_gray,
    input  logic       pix_adv,
    input  logic       frame_start,
    output logic [7:0] gray
);

    logic [7:0] pat3_val;

`ifdef VIDEO_GEN_NOISE_EN
    logic [7:0] lfsr;
    logic       unused_const;

    // Seeded on V_LEAD entry so the first active pixel shows the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (frame_start) begin
            lfsr <= LFSR_SEED;
        end else if (pix_adv) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign pat3_val     = lfsr;
    assign unused_const = ^const_gray;
`else
    logic unused_lfsr_ctl;

    assign pat3_val        = const_gray;
    assign unused_lfsr_ctl = ^{clk, rst_n, pix_adv, frame_start};
`endif

    always_comb begin
        gray = 8'h00;
        case (pattern)
            PAT_HRAMP: gray = x;
            PAT_VRAMP: gray = y;
            PAT_CHECK: gray = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default:   gray = pat3_val;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/video_stream_gen.sv
// ============================================================================
// Module  : video_stream_gen
// Brief   : Frame timing generator with selectable synthetic test pattern.
//           Optional macro VIDEO_GEN_NOISE_EN: LFSR noise on pattern 3.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module video_stream_gen
    import video_gen_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter logic [10:0] H_BLANK   = 11'd160,
    parameter logic [10:0] V_LEAD    = 11'd2,
    parameter logic [10:0] V_BLANK   = 11'd20
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       single_shot,
    input  logic [1:0] pattern_sel,
    input  logic [7:0] const_gray,
    output logic       frame_vsync,
    output logic       frame_href,
    output logic [7:0] img_gray,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [10:0] H_TOTAL = IMG_HDISP + H_BLANK;

    vstate_t     state;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [1:0]  pat_l;
    logic [7:0]  const_l;
    logic        armed;
    logic        end_flag;

    logic [10:0] lines_in_state;
    logic        line_end;
    logic        last_line;
    logic        start_idle;
    logic        restart;
    logic        frame_start;
    logic        href_c;
    logic [7:0]  pat_gray;

    always_comb begin
        lines_in_state = V_LEAD;
        case (state)
            S_ACTIVE:  lines_in_state = IMG_VDISP;
            S_V_BLANK: lines_in_state = V_BLANK;
            default:   lines_in_state = V_LEAD;
        endcase
    end

    assign line_end    = (h_cnt == H_TOTAL - 11'd1);
    assign last_line   = (v_cnt == lines_in_state - 11'd1);
    // armed blocks single-shot re-trigger until enable has been seen low in IDLE
    assign start_idle  = (state == S_IDLE) && enable && (armed || !single_shot);
    assign restart     = (state == S_V_BLANK) && line_end && last_line && enable && !single_shot;
    assign frame_start = start_idle || restart;
    assign href_c      = (state == S_ACTIVE) && (h_cnt < IMG_HDISP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            h_cnt    <= 11'd0;
            v_cnt    <= 11'd0;
            pat_l    <= PAT_HRAMP;
            const_l  <= 8'h00;
            armed    <= 1'b1;
            end_flag <= 1'b0;
        end else begin
            end_flag <= 1'b0;
            if (frame_start) begin
                pat_l   <= pattern_sel;
                const_l <= const_gray;
            end
            if (state == S_IDLE) begin
                h_cnt <= 11'd0;
                v_cnt <= 11'd0;
                if (!enable) begin
                    armed <= 1'b1;
                end
                if (start_idle) begin
                    state <= S_V_LEAD;
                    armed <= 1'b0;
                end
            end else begin
                h_cnt <= line_end ? 11'd0 : h_cnt + 11'd1;
                if (line_end) begin
                    if (last_line) begin
                        v_cnt <= 11'd0;
                        case (state)
                            S_V_LEAD: state <= S_ACTIVE;
                            S_ACTIVE: state <= S_V_BLANK;
                            default: begin
                                end_flag <= 1'b1;
                                state    <= restart ? S_V_LEAD : S_IDLE;
                            end
                        endcase
                    end else begin
                        v_cnt <= v_cnt + 11'd1;
                    end
                end
            end
        end
    end

    video_pattern_unit u_pattern (
        .clk         (clk),
        .rst_n       (rst_n),
        .pattern     (pat_l),
        .x           (h_cnt[7:0]),
        .y           (v_cnt[7:0]),
        .const_gray  (const_l),
        .pix_adv     (href_c),
        .frame_start (frame_start),
        .gray        (pat_gray)
    );

    // Every output is a registered decode of the current state, one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_vsync <= 1'b0;
            frame_href  <= 1'b0;
            img_gray    <= 8'h00;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_vsync <= (state == S_V_LEAD) || (state == S_ACTIVE);
            frame_href  <= href_c;
            img_gray    <= href_c ? pat_gray : 8'h00;
            frame_done  <= end_flag;
            busy        <= (state != S_IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_video_stream_gen.sv
// ============================================================================
// Module  : tb_video_stream_gen
// Brief   : Self-checking bench for video_stream_gen with a frame-position
//           reference model and directed timing/pattern scenarios.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_video_stream_gen;

    localparam int HD = 16;
    localparam int VD = 16;
    localparam int HB = 4;
    localparam int VL = 1;
    localparam int VB = 2;
    localparam int HT = HD + HB;
    localparam int FR = (VL + VD + VB) * HT;

    localparam int SIG_VS   = 0;
    localparam int SIG_HREF = 1;
    localparam int SIG_DONE = 2;
    localparam int SIG_BUSY = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       single_shot;
    logic [1:0] pattern_sel;
    logic [7:0] const_gray;
    logic       frame_vsync;
    logic       frame_href;
    logic [7:0] img_gray;
    logic       frame_done;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    video_stream_gen #(
        .IMG_HDISP (11'(HD)),
        .IMG_VDISP (11'(VD)),
        .H_BLANK   (11'(HB)),
        .V_LEAD    (11'(VL)),
        .V_BLANK   (11'(VB))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .single_shot (single_shot),
        .pattern_sel (pattern_sel),
        .const_gray  (const_gray),
        .frame_vsync (frame_vsync),
        .frame_href  (frame_href),
        .img_gray    (img_gray),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Model: m_pos = cycles since V_LEAD entry (-1 when idle)
    int         m_pos;
    logic       m_done;
    logic       m_seen_low;
    logic [1:0] m_pat;
    logic [7:0] m_const;
    logic [7:0] m_lfsr;
    logic [11:0] exp_vec;

    always @(posedge clk or negedge rst_n) begin
        int line;
        int x;
        logic vs;
        logic hr;
        logic [7:0] g;
        if (!rst_n) begin
            m_pos      = -1;
            m_done     = 1'b0;
            m_seen_low = 1'b1;
            m_pat      = 2'd0;
            m_const    = 8'h00;
            m_lfsr     = 8'hA5;
            exp_vec    = 12'h000;
        end else begin
            line = (m_pos >= 0) ? m_pos / HT : 0;
            x    = (m_pos >= 0) ? m_pos % HT : 0;
            vs   = (m_pos >= 0) && (line < VL + VD);
            hr   = (m_pos >= 0) && (line >= VL) && (line < VL + VD) && (x < HD);
            g    = 8'h00;
            if (hr) begin
                case (m_pat)
                    2'd0: g = 8'(x);
                    2'd1: g = 8'(line - VL);
                    2'd2: g = (((x / 8) + ((line - VL) / 8)) % 2 == 1) ? 8'hFF : 8'h00;
                    default: begin
`ifdef VIDEO_GEN_NOISE_EN
                        g = m_lfsr;
`else
                        g = m_const;
`endif
                    end
                endcase
                m_lfsr = lfsr_step(m_lfsr);
            end
            exp_vec = {vs, hr, g, m_done, (m_pos >= 0)};

            m_done = 1'b0;
            if (m_pos < 0) begin
                if (!enable) begin
                    m_seen_low = 1'b1;
                end else if (!single_shot || m_seen_low) begin
                    m_pos      = 0;
                    m_pat      = pattern_sel;
                    m_const    = const_gray;
                    m_lfsr     = 8'hA5;
                    m_seen_low = 1'b0;
                end
            end else if (m_pos == FR - 1) begin
                m_done = 1'b1;
                if (enable && !single_shot) begin
                    m_pos   = 0;
                    m_pat   = pattern_sel;
                    m_const = const_gray;
                    m_lfsr  = 8'hA5;
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] act;
        act = {frame_vsync, frame_href, img_gray, frame_done, busy};
        checks++;
        if (act !== exp_vec) begin
            errors++;
            $display("FAIL model_cmp t=%0t got vs/href/gray/done/busy=%b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                     $time, act[11], act[10], act[9:2], act[1], act[0],
                     exp_vec[11], exp_vec[10], exp_vec[9:2], exp_vec[1], exp_vec[0]);
        end
    end

    function automatic logic sig(input int w);
        case (w)
            SIG_VS:   return frame_vsync;
            SIG_HREF: return frame_href;
            SIG_DONE: return frame_done;
            default:  return busy;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_for(input int w, input logic val, input int lim);
        int n;
        n = 0;
        while (sig(w) !== val && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (sig(w) !== val) begin
            checks++;
            errors++;
            $display("FAIL timeout signal %0d got %b expected %b", w, sig(w), val);
        end
    endtask

    task automatic check_frame_timing(input string tag);
        int t0;
        int t1;
        int t2;
        wait_for(SIG_VS, 1'b1, 40);
        t0 = cyc;
        wait_for(SIG_HREF, 1'b1, 100);
        chk({tag, "_href_offset"}, cyc - t0, VL * HT);
        t1 = cyc;
        wait_for(SIG_HREF, 1'b0, 100);
        chk({tag, "_burst_len"}, cyc - t1, HD);
        wait_for(SIG_VS, 1'b0, 1000);
        chk({tag, "_vsync_high"}, cyc - t0, 340);
        t2 = cyc;
        wait_for(SIG_VS, 1'b1, 1000);
        chk({tag, "_vsync_low"}, cyc - t2, 40);
        chk({tag, "_done_at_rise"}, int'(frame_done), 1);
        chk({tag, "_period"}, cyc - t0, 380);
    endtask

    initial begin
        int dn;
        int rises;
        logic pv;

        rst_n       = 1'b0;
        enable      = 1'b0;
        single_shot = 1'b0;
        pattern_sel = 2'd0;
        const_gray  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({frame_vsync, frame_href, img_gray, frame_done, busy}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back h-ramp timing
        enable = 1'b1;
        check_frame_timing("ramp");

        // Checker pattern on the next frame
        pattern_sel = 2'd2;
        wait_for(SIG_VS, 1'b0, 1000);
        wait_for(SIG_VS, 1'b1, 100);
        wait_for(SIG_HREF, 1'b1, 100);
        chk("chk_l0_p0", int'(img_gray), 8'h00);
        repeat (8) @(negedge clk);
        chk("chk_l0_p8", int'(img_gray), 8'hFF);
        for (int i = 0; i < 8; i++) begin
            wait_for(SIG_HREF, 1'b0, 100);
            wait_for(SIG_HREF, 1'b1, 100);
        end
        chk("chk_l8_p0", int'(img_gray), 8'hFF);
        repeat (8) @(negedge clk);
        chk("chk_l8_p8", int'(img_gray), 8'h00);

        // Graceful stop with pattern change mid-ACTIVE
        pattern_sel = 2'd0;
        wait_for(SIG_VS, 1'b0, 1000);
        wait_for(SIG_VS, 1'b1, 100);
        wait_for(SIG_HREF, 1'b1, 100);
        wait_for(SIG_HREF, 1'b0, 100);
        wait_for(SIG_HREF, 1'b1, 100);
        repeat (3) @(negedge clk);
        enable      = 1'b0;
        pattern_sel = 2'd1;
        repeat (2) @(negedge clk);
        chk("stop_keeps_hramp", int'(img_gray), 5);
        wait_for(SIG_BUSY, 1'b0, 1000);
        repeat (5) @(negedge clk);
        chk("idle_after_stop", int'({frame_vsync, busy}), 0);
        enable = 1'b1;
        wait_for(SIG_VS, 1'b1, 40);
        wait_for(SIG_HREF, 1'b1, 100);
        for (int i = 0; i < 3; i++) begin
            wait_for(SIG_HREF, 1'b0, 100);
            wait_for(SIG_HREF, 1'b1, 100);
        end
        chk("vramp_line3", int'(img_gray), 3);

        // Single-shot
        enable = 1'b0;
        wait_for(SIG_BUSY, 1'b0, 1000);
        single_shot = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        dn    = 0;
        rises = 0;
        pv    = frame_vsync;
        repeat (900) begin
            @(negedge clk);
            if (frame_done) dn++;
            if (frame_vsync && !pv) rises++;
            pv = frame_vsync;
        end
        chk("ss_done_count", dn, 1);
        chk("ss_vsync_rises", rises, 1);
        chk("ss_busy_end", int'(busy), 0);

        // Asynchronous reset mid-ACTIVE, then clean restart
        single_shot = 1'b0;
        pattern_sel = 2'd0;
        enable      = 1'b1;
        wait_for(SIG_HREF, 1'b1, 200);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", int'({frame_vsync, frame_href, img_gray, busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame_timing("post_rst");

        // Randomized run checked by the model
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ($urandom_range(299) == 0) enable = ~enable;
            if ($urandom_range(799) == 0) single_shot = ~single_shot;
            if ($urandom_range(59) == 0) begin
                pattern_sel = 2'($urandom);
                const_gray  = 8'($urandom);
            end
        end

        // Pattern 3: constant level or LFSR noise
        enable = 1'b0;
        single_shot = 1'b0;
        wait_for(SIG_BUSY, 1'b0, 1000);
        pattern_sel = 2'd3;
        const_gray  = 8'h3C;
        enable      = 1'b1;
        wait_for(SIG_HREF, 1'b1, 100);
`ifdef VIDEO_GEN_NOISE_EN
        chk("noise_px0", int'(img_gray), 8'hA5);
        @(negedge clk);
        chk("noise_px1", int'(img_gray), 8'h4A);
        @(negedge clk);
        // third value follows from the tap equation applied to 4A
        chk("noise_px2", int'(img_gray), 8'h95);
        wait_for(SIG_VS, 1'b0, 1000);
        wait_for(SIG_VS, 1'b1, 100);
        wait_for(SIG_HREF, 1'b1, 100);
        chk("noise_restart", int'(img_gray), 8'hA5);
`else
        chk("const_px0", int'(img_gray), 8'h3C);
        const_gray = 8'h81;
        repeat (4) @(negedge clk);
        chk("const_latched", int'(img_gray), 8'h3C);
        wait_for(SIG_VS, 1'b0, 1000);
        wait_for(SIG_VS, 1'b1, 100);
        wait_for(SIG_HREF, 1'b1, 100);
        chk("const_next_frame", int'(img_gray), 8'h81);
`endif
        enable = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
